md_sched: RTL

Multi-cycle multiply/divide scheduler for the EX stage. It accepts a HI/LO arithmetic op (mult, multu, div, divu) from the EX datapath, sequences the external fixed-latency multiplier and the iterative divider through their start/ready/annul handshakes, and raises `stallreq` while the op runs. It holds the 64-bit result until the pipeline advances, and aborts cleanly on `flush`. It sits between the EX datapath and the `mul`/`div` units; the parent feeds `hi_o`/`lo_o` into the hilo bus.

---
 rtl/md_sched_pkg.sv | 44 ++++
 rtl/md_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/md_sched_pkg.sv
// Shared types and constants for the EX-stage multiply/divide scheduler.
// Op decode lives here so every user resolves overlapping op bits identically.
package md_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } md_state_e;

    localparam logic Stop              = 1'b1;
    localparam logic NoStop            = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] DivZeroQuot = 32'hFFFF_FFFF;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_dec_t;

    // Priority when several op bits are set: div > divu > mult > multu.
    function automatic md_dec_t md_decode(input logic div, input logic divu,
                                          input logic mult, input logic multu);
        md_dec_t dec;
        dec.is_div    = div | divu;
        dec.is_signed = 1'b0;
        if (div) begin
            dec.is_signed = 1'b1;
        end else if (divu) begin
            dec.is_signed = 1'b0;
        end else if (mult) begin
            dec.is_signed = 1'b1;
        end else if (multu) begin
            dec.is_signed = 1'b0;
        end
        return dec;
    endfunction

endpackage

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler: sequences the external multiplier and
// divider, stalls EX while an op runs and holds the 64-bit result until EX advances.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        inst_div,
    input  logic        inst_divu,
    input  logic        inst_mult,
    input  logic        inst_multu,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq,
    output logic        result_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e   state;
    logic [CntW-1:0] cnt;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        signed_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic    md_op;
    md_dec_t dec;
    logic    in_mul;
    logic    in_div;

    assign md_op  = inst_div | inst_divu | inst_mult | inst_multu;
    assign dec    = md_decode(inst_div, inst_divu, inst_mult, inst_multu);
    assign in_mul = (state == StMul);
    assign in_div = (state == StDiv);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (flush) begin
            // Flush wins over every transition, including a coincident div_ready.
            state <= StIdle;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (md_op) begin
                        opa_q    <= src_a;
                        opb_q    <= src_b;
                        signed_q <= dec.is_signed;
                        if (!dec.is_div) begin
                            cnt   <= CntW'(MUL_LAT - 1);
                            state <= StMul;
                        end else if (src_b != 32'd0) begin
                            state <= StDiv;
                        end else begin
                            hi_q  <= src_a;
                            lo_q  <= DivZeroQuot;
                            state <= StDone;
                        end
                    end
                end
                StMul: begin
                    if (cnt == '0) begin
                        hi_q  <= mul_result[63:32];
                        lo_q  <= mul_result[31:0];
                        state <= StDone;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StDiv: begin
                    if (div_ready == DivResultReady) begin
                        hi_q  <= div_result[63:32];
                        lo_q  <= div_result[31:0];
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (!ex_stall) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Combinational so the accept cycle itself already holds EX.
    assign stallreq = (~flush & ((state == StIdle & md_op) | in_mul | in_div)) ? Stop : NoStop;

    assign result_valid = (state == StDone);
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

    assign mul_signed = in_mul & signed_q;
    assign mul_a      = in_mul ? opa_q : 32'd0;
    assign mul_b      = in_mul ? opb_q : 32'd0;

    assign div_start  = (in_div & ~flush & (div_ready == DivResultNotReady)) ? DivStart : DivStop;
    assign div_annul  = in_div & flush;
    assign div_signed = in_div & signed_q;
    assign div_opa    = in_div ? opa_q : 32'd0;
    assign div_opb    = in_div ? opb_q : 32'd0;

endmodule
